// File: rtl/pipeline3_core_if.sv
// Instruction-fetch, write-back and debug signals between the source/display side and pipeline3_core.
// The source side is the master; the core is the slave.
interface pipeline3_core_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 12
);
    logic [15:0]       instr_i;
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [PC_W-1:0]   pc_o;
    logic              wb_valid_o;
    logic [3:0]        wb_rd_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [3:0]        dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;
    logic              mul_busy_o;

    modport master (
        output instr_i, instr_valid_i, dbg_addr_i,
        input  instr_ready_o, pc_o, wb_valid_o, wb_rd_o, wb_data_o, dbg_data_o, mul_busy_o
    );

    modport slave (
        input  instr_i, instr_valid_i, dbg_addr_i,
        output instr_ready_o, pc_o, wb_valid_o, wb_rd_o, wb_data_o, dbg_data_o, mul_busy_o
    );
endinterface

// File: rtl/pipeline3_core.sv
// Three-stage (D/E/M) in-order core for the 16-bit ISA: full forwarding, one-slot
// taken-branch squash, and a MUL_CYCLES-latency multiplier with HI/LO interlock.
module pipeline3_core #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 12,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    pipeline3_core_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR,
        OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI,
        OP_JMP, OP_BEZ, OP_MFLO, OP_MFHI, OP_MUL
    } op_e;

    typedef struct packed {
        logic              valid;
        op_e               op;
        logic [3:0]        rd;
        logic [3:0]        rs1;
        logic [3:0]        rs2;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [PC_W-1:0]   pc;
    } d_stage_t;

    d_stage_t            d_q;
    logic [DATA_W-1:0]   rf [16];
    logic [PC_W-1:0]     pc_q;
    logic                wb_valid_q;
    logic [3:0]          wb_rd_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic [DATA_W-1:0]   hi_q, lo_q, mul_a_q, mul_b_q;
    logic [CNT_W-1:0]    mul_cnt_q;

    op_e                 in_op;
    logic                mul_busy, stall, accept, taken, d_writes;
    logic [DATA_W-1:0]   alu_y, imm, op_a, op_b;
    logic [PC_W-1:0]     target, br_off;
    logic [2*DATA_W-1:0] product;

    function automatic logic writes_rd(input op_e op);
        return !(op inside {OP_JMP, OP_BEZ, OP_MUL});
    endfunction

    assign in_op    = op_e'(bus.instr_i[15:12]);
    assign mul_busy = (mul_cnt_q != '0);
    assign d_writes = d_q.valid && writes_rd(d_q.op);
    assign stall    = (in_op inside {OP_MUL, OP_MFLO, OP_MFHI}) &&
                      (mul_busy || (d_q.valid && d_q.op == OP_MUL));
    assign accept   = bus.instr_valid_i && !stall;
    assign imm      = DATA_W'(d_q.rs1);
    assign br_off   = {{(PC_W-8){d_q.rd[3]}}, d_q.rd, d_q.rs2};
    assign product  = {{DATA_W{1'b0}}, mul_a_q} * {{DATA_W{1'b0}}, mul_b_q};

    // E stage: result of the instruction currently held in D.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        alu_y = '0;
        case (d_q.op)
            OP_ADD:  alu_y = d_q.a + d_q.b;
            OP_SUB:  alu_y = d_q.a - d_q.b;
            OP_SLT:  alu_y = DATA_W'(d_q.a < d_q.b);
            OP_AND:  alu_y = d_q.a & d_q.b;
            OP_OR:   alu_y = d_q.a | d_q.b;
            OP_XOR:  alu_y = d_q.a ^ d_q.b;
            OP_ANDI: alu_y = d_q.b & imm;
            OP_ORI:  alu_y = d_q.b | imm;
            OP_XORI: alu_y = d_q.b ^ imm;
            OP_ADDI: alu_y = d_q.b + imm;
            OP_SUBI: alu_y = d_q.b - imm;
            OP_MFLO: alu_y = lo_q;
            OP_MFHI: alu_y = hi_q;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = '0;
        if (d_q.valid && d_q.op == OP_JMP) begin
            taken  = 1'b1;
            target = PC_W'({d_q.rd, d_q.rs1, d_q.rs2});
        end else if (d_q.valid && d_q.op == OP_BEZ) begin
            taken  = (d_q.a == '0);
            target = d_q.pc + br_off;
        end
    end

    // Youngest producer wins: instruction in D, then the M register, then the file.
    function automatic logic [DATA_W-1:0] fwd(input logic [3:0] src);
        if (d_writes && d_q.rd == src)       return alu_y;
        else if (wb_valid_q && wb_rd_q == src) return wb_data_q;
        else                                   return rf[src];
    endfunction

    always_comb begin
        op_a = fwd(bus.instr_i[7:4]);
        op_b = fwd(bus.instr_i[3:0]);
    end

    // A taken branch overrides both a normal accept and a stall.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc_q <= '0;
            d_q  <= '0;
        end else begin
            if (taken)       pc_q <= target;
            else if (accept) pc_q <= pc_q + PC_W'(1);
            d_q.valid <= accept && !taken;
            d_q.op    <= in_op;
            d_q.rd    <= bus.instr_i[11:8];
            d_q.rs1   <= bus.instr_i[7:4];
            d_q.rs2   <= bus.instr_i[3:0];
            d_q.a     <= op_a;
            d_q.b     <= op_b;
            d_q.pc    <= pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            // NOTE: the register file is architecturally cleared by reset, so it resets like any flop.
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            wb_valid_q <= d_writes;
            if (d_writes) begin
                wb_rd_q   <= d_q.rd;
                wb_data_q <= alu_y;
            end
            if (wb_valid_q) rf[wb_rd_q] <= wb_data_q;
        end
    end

    // Operands are captured as MUL leaves D; HI/LO load as the count reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_cnt_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (d_q.valid && d_q.op == OP_MUL) begin
            mul_cnt_q <= CNT_W'(MUL_CYCLES);
            mul_a_q   <= d_q.a;
            mul_b_q   <= d_q.b;
        end else if (mul_busy) begin
            mul_cnt_q <= mul_cnt_q - CNT_W'(1);
            if (mul_cnt_q == CNT_W'(1)) {hi_q, lo_q} <= product;
        end
    end

    assign bus.instr_ready_o = !stall;
    assign bus.pc_o          = pc_q;
    assign bus.wb_valid_o    = wb_valid_q;
    assign bus.wb_rd_o       = wb_rd_q;
    assign bus.wb_data_o     = wb_data_q;
    assign bus.dbg_data_o    = rf[bus.dbg_addr_i];
    assign bus.mul_busy_o    = mul_busy;
endmodule

// File: tb/tb_pipeline3_core.sv
// Directed bench for pipeline3_core: write-back timing, forwarding, branches,
// multiplier interlock and reset during a multiply.
module tb_pipeline3_core;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   n_low;
    int   n_busy;

    pipeline3_core_if #(.DATA_W(16), .PC_W(12)) bus ();

    pipeline3_core #(.DATA_W(16), .PC_W(12), .MUL_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins);
        bus.instr_i       = ins;
        bus.instr_valid_i = 1'b1;
        tick();
        bus.instr_valid_i = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        bus.instr_i       = 16'h0000;
        bus.instr_valid_i = 1'b0;
        bus.dbg_addr_i    = 4'd1;
        reset = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_pc", bus.pc_o, 0);
        check("rst_wb_valid", bus.wb_valid_o, 0);
        check("rst_wb_rd", bus.wb_rd_o, 0);
        check("rst_wb_data", bus.wb_data_o, 0);
        check("rst_busy", bus.mul_busy_o, 0);
        check("rst_ready", bus.instr_ready_o, 1);
        check("rst_dbg_r1", bus.dbg_data_o, 0);

        // ADDI R1,R0,5
        send(16'h9150);
        check("addi_pc", bus.pc_o, 1);
        check("addi_wb_early", bus.wb_valid_o, 0);
        tick();
        check("addi_wb_valid", bus.wb_valid_o, 1);
        check("addi_wb_rd", bus.wb_rd_o, 1);
        check("addi_wb_data", bus.wb_data_o, 5);
        check("addi_dbg_before", bus.dbg_data_o, 0);
        tick();
        check("addi_dbg_r1", bus.dbg_data_o, 5);

        // ADD R2=R1+R1 then SUB R3=R2-R1, back to back
        send(16'h0211);
        check("add_ready", bus.instr_ready_o, 1);
        send(16'h1321);
        check("add_wb_rd", bus.wb_rd_o, 2);
        check("add_wb_data", bus.wb_data_o, 10);
        tick();
        check("sub_wb_valid", bus.wb_valid_o, 1);
        check("sub_wb_rd", bus.wb_rd_o, 3);
        check("sub_wb_data", bus.wb_data_o, 5);
        check("btb_pc", bus.pc_o, 3);

        // JMP 0x020 followed by ADD R6=R1+R1, which must be squashed
        send(16'hB020);
        send(16'h0611);
        check("jmp_pc", bus.pc_o, 12'h020);
        check("jmp_wb_none", bus.wb_valid_o, 0);
        tick();
        check("squash_wb_none", bus.wb_valid_o, 0);
        bus.dbg_addr_i = 4'd6;
        tick();
        check("squash_r6", bus.dbg_data_o, 0);

        // BEZ R0 (taken, offset -2) at pc 8
        send(16'hB008);
        tick();
        check("jmp8_pc", bus.pc_o, 8);
        send(16'hCF0E);
        check("bez_accept_pc", bus.pc_o, 9);
        tick();
        check("bez_taken_pc", bus.pc_o, 6);
        check("bez_wb_none", bus.wb_valid_o, 0);

        // BEZ R1=5 (not taken) at pc 8 followed by ADDI R7,R0,3
        send(16'hB008);
        tick();
        send(16'hC010);
        check("bez_nt_pc", bus.pc_o, 9);
        send(16'h9730);
        check("bez_nt_fall_pc", bus.pc_o, 10);
        tick();
        check("bez_nt_wb_valid", bus.wb_valid_o, 1);
        check("bez_nt_wb_rd", bus.wb_rd_o, 7);
        check("bez_nt_wb_data", bus.wb_data_o, 3);

        // R1=0xFFFF, R2=2, MUL, then MFHI R4 straight away
        send(16'hA110);
        send(16'h9220);
        send(16'hF012);
        bus.instr_i       = 16'hE400;
        bus.instr_valid_i = 1'b1;
        n_low  = 0;
        n_busy = 0;
        while (!bus.instr_ready_o && n_low < 20) begin
            n_low++;
            if (bus.mul_busy_o) n_busy++;
            tick();
        end
        check("mul_ready_low", n_low, 5);
        check("mul_busy_cycles", n_busy, 4);
        tick();
        bus.instr_valid_i = 1'b0;
        tick();
        check("mfhi_wb_valid", bus.wb_valid_o, 1);
        check("mfhi_wb_rd", bus.wb_rd_o, 4);
        check("mfhi_wb_data", bus.wb_data_o, 16'h0001);
        send(16'hD500);
        check("mflo_ready", bus.instr_ready_o, 1);
        tick();
        check("mflo_wb_rd", bus.wb_rd_o, 5);
        check("mflo_wb_data", bus.wb_data_o, 16'hFFFE);
        bus.dbg_addr_i = 4'd4;
        tick();
        check("mfhi_dbg_r4", bus.dbg_data_o, 16'h0001);

        // Reset while the multiplier is running
        send(16'hF012);
        tick();
        check("mul2_busy", bus.mul_busy_o, 1);
        reset = 1'b1;
        #1;
        check("mrst_busy", bus.mul_busy_o, 0);
        check("mrst_pc", bus.pc_o, 0);
        check("mrst_dbg_r4", bus.dbg_data_o, 0);
        tick();
        reset = 1'b0;
        bus.dbg_addr_i = 4'd1;
        #1;
        check("mrst_dbg_r1", bus.dbg_data_o, 0);
        send(16'hE400);
        tick();
        check("mrst_mfhi_valid", bus.wb_valid_o, 1);
        check("mrst_mfhi_rd", bus.wb_rd_o, 4);
        check("mrst_mfhi_data", bus.wb_data_o, 0);
        tick();
        check("mrst_busy_idle", bus.mul_busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
